// File: rtl/pxs_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// pxs_vga_timing_ctrl
//
// Purpose:
//   Generates a progressive VGA raster (640x480 at defaults) from one system
//   clock. A programmable divider sets the pixel rate. Frames start and stop
//   only on frame boundaries. The outputs feed the stream join stage.
//
// Ports:
//   Clk          in   system clock
//   Rst_n        in   asynchronous active-low reset
//   Run          in   level: high = generate frames, low = stop at frame end
//   HSync        out  horizontal sync (asserted level = SYNC_POL)
//   VSync        out  vertical sync   (asserted level = SYNC_POL)
//   XCoord       out  horizontal count 0..H_total-1
//   YCoord       out  vertical count   0..V_total-1
//   ActiveVideo  out  high while XCoord < H_ACT and YCoord < V_ACT
//   PixEn        out  one-clock pulse on the first clock of each pixel
//   FrameStart   out  PixEn qualified with pixel (0,0)
//   Running      out  high while frames are being generated
// ---------------------------------------------------------------------------
module pxs_vga_timing_ctrl #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACT    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACT    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Run,
   output logic       HSync,
   output logic       VSync,
   output logic [9:0] XCoord,
   output logic [9:0] YCoord,
   output logic       ActiveVideo,
   output logic       PixEn,
   output logic       FrameStart,
   output logic       Running
);

   localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_ACT    = 10'(H_ACT);
   localparam logic [9:0] Y_ACT    = 10'(V_ACT);
   localparam logic [9:0] HS_FIRST = 10'(H_ACT + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACT + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACT + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACT + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [9:0]       x, x_nxt;
   logic [9:0]       y, y_nxt;
   logic             tick;
   logic             last_pix;
   logic             gen;

   assign tick     = (div == DIV_LAST);
   assign last_pix = (x == X_LAST) && (y == Y_LAST);
   assign gen      = (state != ST_IDLE);

   // ------------------------------------------------------------------------
   // State and raster counters
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= ST_IDLE;
         div   <= '0;
         x     <= '0;
         y     <= '0;
      end else begin
         state <= state_nxt;
         div   <= div_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div;
      x_nxt     = x;
      y_nxt     = y;

      case (state)
         ST_IDLE: begin
            div_nxt = '0;
            x_nxt   = '0;
            y_nxt   = '0;
            if (Run) begin
               state_nxt = ST_RUN;
            end
         end

         ST_RUN, ST_DRAIN: begin
            // RUN and DRAIN differ only in name until the last tick of the
            // frame; there, Run alone decides whether another frame follows.
            if (state == ST_RUN && !Run) begin
               state_nxt = ST_DRAIN;
            end else if (state == ST_DRAIN && Run) begin
               state_nxt = ST_RUN;
            end

            div_nxt = tick ? '0 : div + 1'b1;

            if (tick) begin
               if (last_pix) begin
                  x_nxt     = '0;
                  y_nxt     = '0;
                  state_nxt = Run ? ST_RUN : ST_IDLE;
               end else if (x == X_LAST) begin
                  x_nxt = '0;
                  y_nxt = y + 10'd1;
               end else begin
                  x_nxt = x + 10'd1;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            div_nxt   = '0;
            x_nxt     = '0;
            y_nxt     = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output registers: every field comes from the same state/counter
   // snapshot, so all outputs change together one clock after the counters.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         HSync       <= ~SYNC_POL;
         VSync       <= ~SYNC_POL;
         XCoord      <= '0;
         YCoord      <= '0;
         ActiveVideo <= 1'b0;
         PixEn       <= 1'b0;
         FrameStart  <= 1'b0;
         Running     <= 1'b0;
      end else begin
         HSync       <= (gen && x >= HS_FIRST && x <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
         VSync       <= (gen && y >= VS_FIRST && y <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
         XCoord      <= gen ? x : '0;
         YCoord      <= gen ? y : '0;
         ActiveVideo <= gen && (x < X_ACT) && (y < Y_ACT);
         PixEn       <= gen && (div == '0);
         FrameStart  <= gen && (div == '0) && (x == '0) && (y == '0);
         Running     <= gen;
      end
   end

endmodule

// File: tb/tb_pxs_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pxs_vga_timing_ctrl
//
// Two reduced-raster instances share clock, reset and Run:
//   dut0: CLK_DIV=3, active-low syncs, 31x17 raster
//   dut1: CLK_DIV=1, active-high syncs, 15x10 raster
// A reference model tracks a linear clock position within the frame and
// derives every expected output from it arithmetically.
// ---------------------------------------------------------------------------
module tb_pxs_vga_timing_ctrl;

   localparam int unsigned D0_DIV = 3;
   localparam int unsigned D0_HA = 16, D0_HF = 4, D0_HS = 6, D0_HB = 5;
   localparam int unsigned D0_VA = 10, D0_VF = 2, D0_VS = 2, D0_VB = 3;
   localparam bit          D0_POL = 1'b0;
   localparam int unsigned D0_N = (D0_HA+D0_HF+D0_HS+D0_HB) * (D0_VA+D0_VF+D0_VS+D0_VB) * D0_DIV;

   localparam int unsigned D1_DIV = 1;
   localparam int unsigned D1_HA = 8, D1_HF = 2, D1_HS = 3, D1_HB = 2;
   localparam int unsigned D1_VA = 5, D1_VF = 1, D1_VS = 2, D1_VB = 2;
   localparam bit          D1_POL = 1'b1;
   localparam int unsigned D1_N = (D1_HA+D1_HF+D1_HS+D1_HB) * (D1_VA+D1_VF+D1_VS+D1_VB) * D1_DIV;

   logic Clk = 1'b0;
   logic Rst_n;
   logic Run;

   logic       hs0, vs0, av0, pe0, fs0, rn0;
   logic [9:0] x0, y0;
   logic       hs1, vs1, av1, pe1, fs1, rn1;
   logic [9:0] x1, y1;

   logic [25:0] obs0, obs1;
   logic [25:0] exp0, exp1;
   bit          on0, on1;
   int unsigned c0, c1;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          chk_en = 1'b0;

   always #5 Clk = ~Clk;

   pxs_vga_timing_ctrl #(
      .CLK_DIV(D0_DIV), .H_ACT(D0_HA), .H_FP(D0_HF), .H_SYNC(D0_HS), .H_BP(D0_HB),
      .V_ACT(D0_VA), .V_FP(D0_VF), .V_SYNC(D0_VS), .V_BP(D0_VB), .SYNC_POL(D0_POL)
   ) dut0 (
      .Clk(Clk), .Rst_n(Rst_n), .Run(Run),
      .HSync(hs0), .VSync(vs0), .XCoord(x0), .YCoord(y0),
      .ActiveVideo(av0), .PixEn(pe0), .FrameStart(fs0), .Running(rn0)
   );

   pxs_vga_timing_ctrl #(
      .CLK_DIV(D1_DIV), .H_ACT(D1_HA), .H_FP(D1_HF), .H_SYNC(D1_HS), .H_BP(D1_HB),
      .V_ACT(D1_VA), .V_FP(D1_VF), .V_SYNC(D1_VS), .V_BP(D1_VB), .SYNC_POL(D1_POL)
   ) dut1 (
      .Clk(Clk), .Rst_n(Rst_n), .Run(Run),
      .HSync(hs1), .VSync(vs1), .XCoord(x1), .YCoord(y1),
      .ActiveVideo(av1), .PixEn(pe1), .FrameStart(fs1), .Running(rn1)
   );

   assign obs0 = {hs0, vs0, x0, y0, av0, pe0, fs0, rn0};
   assign obs1 = {hs1, vs1, x1, y1, av1, pe1, fs1, rn1};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, want, $time);
      end
   endtask

   // Expected output vector for frame position c (clocks since frame start).
   function automatic logic [25:0] model_out(
      input int unsigned dv, ha, hf, hsy, hb, va, vf, vsy, vb,
      input bit pol, input bit on, input int unsigned c);
      int unsigned ht, pix, x, y;
      logic hs, vs, act, pe, fs;
      if (!on) return {~pol, ~pol, 20'd0, 4'b0000};
      ht  = ha + hf + hsy + hb;
      pix = c / dv;
      x   = pix % ht;
      y   = pix / ht;
      hs  = (x >= ha + hf && x < ha + hf + hsy) ? pol : ~pol;
      vs  = (y >= va + vf && y < va + vf + vsy) ? pol : ~pol;
      act = (x < ha) && (y < va);
      pe  = (c % dv) == 0;
      fs  = (c == 0);
      return {hs, vs, 10'(x), 10'(y), act, pe, fs, 1'b1};
   endfunction

   // Reference model: outputs registered one clock behind the frame position.
   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         on0 <= 1'b0; c0 <= 0;
         on1 <= 1'b0; c1 <= 0;
         exp0 <= model_out(D0_DIV, D0_HA, D0_HF, D0_HS, D0_HB, D0_VA, D0_VF, D0_VS, D0_VB, D0_POL, 1'b0, 0);
         exp1 <= model_out(D1_DIV, D1_HA, D1_HF, D1_HS, D1_HB, D1_VA, D1_VF, D1_VS, D1_VB, D1_POL, 1'b0, 0);
      end else begin
         exp0 <= model_out(D0_DIV, D0_HA, D0_HF, D0_HS, D0_HB, D0_VA, D0_VF, D0_VS, D0_VB, D0_POL, on0, c0);
         exp1 <= model_out(D1_DIV, D1_HA, D1_HF, D1_HS, D1_HB, D1_VA, D1_VF, D1_VS, D1_VB, D1_POL, on1, c1);
         if (!on0) begin
            if (Run) begin on0 <= 1'b1; c0 <= 0; end
         end else if (c0 == D0_N - 1) begin
            on0 <= Run; c0 <= 0;
         end else begin
            c0 <= c0 + 1;
         end
         if (!on1) begin
            if (Run) begin on1 <= 1'b1; c1 <= 0; end
         end else if (c1 == D1_N - 1) begin
            on1 <= Run; c1 <= 0;
         end else begin
            c1 <= c1 + 1;
         end
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         check_eq("cyc_dut0", 32'(obs0), 32'(exp0));
         check_eq("cyc_dut1", 32'(obs1), 32'(exp1));
      end
   end

   localparam logic [25:0] RST0    = {1'b1, 1'b1, 20'd0, 4'b0000};
   localparam logic [25:0] RST1    = {1'b0, 1'b0, 20'd0, 4'b0000};
   localparam logic [25:0] FIRST0  = {1'b1, 1'b1, 20'd0, 4'b1111};

   task automatic async_reset_check(input string tag);
      @(posedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      check_eq({tag, "_d0"}, 32'(obs0), 32'(RST0));
      check_eq({tag, "_d1"}, 32'(obs1), 32'(RST1));
   endtask

   initial begin
      int unsigned n_fs, n_act, n_hs, n_vs, seg_len, wait_i;
      bit          found;
      logic [9:0]  last_x, last_y;

      Rst_n = 1'b1;
      Run   = 1'b0;
      #1 Rst_n = 1'b0;
      #1;
      check_eq("reset_d0", 32'(obs0), 32'(RST0));
      check_eq("reset_d1", 32'(obs1), 32'(RST1));
      chk_en = 1'b1;

      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (5) @(negedge Clk);

      // Three back-to-back frames on dut1, counting line/frame features.
      Run = 1'b1;
      @(posedge Clk);
      @(posedge Clk);
      n_fs = 0; n_act = 0; n_hs = 0; n_vs = 0;
      repeat (3 * D1_N) begin
         @(negedge Clk);
         if (fs1) n_fs++;
         if (pe1 && av1) n_act++;
         if (pe1 && hs1) n_hs++;
         if (pe1 && vs1) n_vs++;
      end
      check_eq("frames_d1", n_fs, 3);
      check_eq("active_px_d1", n_act, 3 * D1_HA * D1_VA);
      check_eq("hsync_px_d1", n_hs, 3 * D1_HS * (D1_VA + D1_VF + D1_VS + D1_VB));
      check_eq("vsync_px_d1", n_vs, 3 * D1_VS * (D1_HA + D1_HF + D1_HS + D1_HB));

      // Drop Run mid-frame on dut0: frame completes, no further FrameStart.
      found = 1'b0;
      for (wait_i = 0; wait_i < 2 * D0_N && !found; wait_i++) begin
         @(negedge Clk);
         found = (x0 == 10'd5 && y0 == 10'd3);
      end
      check_eq("reach_5_3", 32'(found), 1);
      Run = 1'b0;
      n_fs = 0; last_x = x0; last_y = y0;
      found = 1'b0;
      for (wait_i = 0; wait_i < 2 * D0_N && !found; wait_i++) begin
         @(negedge Clk);
         if (fs0) n_fs++;
         if (rn0) begin last_x = x0; last_y = y0; end
         found = !rn0;
      end
      check_eq("drain_idle", 32'(found), 1);
      check_eq("drain_fs", n_fs, 0);
      check_eq("drain_last", {12'd0, last_x, last_y},
               {12'd0, 10'(D0_HA+D0_HF+D0_HS+D0_HB-1), 10'(D0_VA+D0_VF+D0_VS+D0_VB-1)});
      repeat (4) @(negedge Clk);

      Run = 1'b1;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      check_eq("restart_d0", 32'(obs0), 32'(FIRST0));

      // Mid-pixel asynchronous reset, then restart from (0,0).
      found = 1'b0;
      for (wait_i = 0; wait_i < 2 * D0_N && !found; wait_i++) begin
         @(negedge Clk);
         found = (x0 == 10'd20 && y0 == 10'd8 && !pe0);
      end
      check_eq("reach_20_8", 32'(found), 1);
      #2 Rst_n = 1'b0;
      #1;
      check_eq("midpix_rst_d0", 32'(obs0), 32'(RST0));
      check_eq("midpix_rst_d1", 32'(obs1), 32'(RST1));
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      check_eq("rst_restart_d0", 32'(obs0), 32'(FIRST0));

      // Random Run segments with occasional asynchronous resets.
      for (int unsigned seg = 0; seg < 40; seg++) begin
         Run = ($urandom_range(0, 3) != 0);
         seg_len = $urandom_range(1, 900);
         repeat (seg_len) @(negedge Clk);
         if ($urandom_range(0, 7) == 0) begin
            async_reset_check("rand_rst");
            repeat ($urandom_range(1, 3)) @(negedge Clk);
            Rst_n = 1'b1;
         end
      end

      Run = 1'b0;
      repeat (2 * D0_N + 4) @(negedge Clk);
      check_eq("final_idle_d0", 32'(obs0), 32'(RST0));
      check_eq("final_idle_d1", 32'(obs1), 32'(RST1));

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pxs_vga_timing_ctrl.md
# pxs_vga_timing_ctrl

Timing controller that sequences a 640x480 progressive VGA pixel stream. It generates HSync, VSync, XCoord, YCoord and ActiveVideo from a single system clock using a programmable pixel-rate divider. It adds frame-aligned start/stop control and status. Its outputs feed the stream join stage, which packs the 23-bit VGA stream consumed by downstream Pxs processing blocks.

## Interface
- CLK_DIV, 2, system clocks per pixel (≥1; 2 gives 25 MHz from 50 MHz)
- H_ACT/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal phase lengths in pixels
- V_ACT/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical phase lengths in lines
- SYNC_POL, 0, asserted level of HSync/VSync (0 = active-low)

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- Run  in  1  level; high = generate frames, low = stop at end of current frame
- HSync  out  1  horizontal sync
- VSync  out  1  vertical sync
- XCoord  out  10  horizontal count 0..H_total-1
- YCoord  out  10  vertical count 0..V_total-1
- ActiveVideo  out  1  high when XCoord<H_ACT and YCoord<V_ACT
- PixEn  out  1  one-clock pulse marking the first cycle of each new pixel
- FrameStart  out  1  one-clock pulse, coincident with PixEn, when (0,0) is presented
- Running  out  1  high while frames are being generated

## Operation
- H_total = H_ACT+H_FP+H_SYNC+H_BP (800). V_total = V_ACT+V_FP+V_SYNC+V_BP (525). Both must be ≤1024.
- Divider: counter 0..CLK_DIV-1 runs only in RUN state. A tick occurs when it wraps. With CLK_DIV=1, every clock is a tick.
- FSM states:
  - IDLE: divider and counters held at 0.
  - RUN: counters advance on each tick.
  - DRAIN: Run has dropped; counters keep advancing until the frame ends.
- Transitions:
  - IDLE→RUN when Run=1.
  - RUN→DRAIN when Run=0.
  - DRAIN→RUN when Run=1 again; no restart, the frame continues.
  - RUN/DRAIN: on the tick where (X,Y)=(H_total-1,V_total-1), counters wrap to (0,0). Next state is RUN if Run=1, else IDLE.
- X wraps at H_total-1 and increments Y at that point. Y wraps at V_total-1.
- HSync is asserted (=SYNC_POL) for X in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1], i.e. 656..751. Otherwise it is at the deasserted level.
- VSync is asserted for Y in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC-1], i.e. 490..491.
- All outputs are registered and derived from the same counter values, so there is no skew between fields.
- In IDLE: HSync=VSync=~SYNC_POL, ActiveVideo=0, X=Y=0, PixEn=FrameStart=0, Running=0.

## Timing
- Reset value of every output: HSync=VSync=~SYNC_POL, XCoord=YCoord=0, ActiveVideo=0, PixEn=0, FrameStart=0, Running=0. FSM=IDLE.
- Run sampled high at clock edge N (in IDLE): at edge N+1, Running=1, PixEn=1, FrameStart=1, outputs present pixel (0,0) with ActiveVideo=1.
- Each pixel's values are held for exactly CLK_DIV clocks. PixEn is high only in the first of those clocks.
- Frame period: H_total·V_total·CLK_DIV clocks (840000 at defaults).
- Run=0 mid-frame: the frame completes through (799,524). On the following tick the block enters IDLE and outputs take IDLE values; no (0,0) pixel and no FrameStart are emitted.
- Run toggled 1→0→1 within a frame: no visible effect. Running stays 1.
- Run=0 on the exact last-pixel tick: that tick transitions to IDLE.
- Rst_n low at any time: all outputs take reset values immediately (asynchronously). Restart requires Rst_n high and Run=1.

## Test plan
- Reset, then Run=1 at defaults → FrameStart pulses every 840000 clocks; PixEn every 2 clocks; XCoord sequence 0..799; YCoord increments when X wraps from 799 to 0.
- Line check → HSync low exactly for X=656..751 (96 pixels, 192 clocks); ActiveVideo high only for X<640 and Y<480 (307200 active pixels per frame).
- Frame check → VSync low exactly for Y=490..491 (1600 pixel ticks); HSync and VSync transitions aligned to PixEn cycles.
- Run dropped at (100,200) → output continues to (799,524), then IDLE values and Running=0 one tick later; no FrameStart. Re-assert Run → first pixel (0,0) one clock after sampling.
- Rst_n asserted at (300,300) mid-pixel → outputs at reset values before the next clock edge. After release with Run=1, the frame restarts at (0,0) with FrameStart.
- CLK_DIV=1, SYNC_POL=1 → PixEn constantly high; frame of 420000 clocks; HSync and VSync active-high over the same ranges.
